odd_wb_pipe: RTL and testbench

Parametrised result-staging and forwarding pipe for the odd pipeline. It merges the results of up to NUM_UNITS fixed-latency execution units (permute, local store, branch, and future units) into one shift chain of DEPTH stages. Each result is inserted at the stage equal to its unit's latency, and the chain drives a single registered write-back port to the register table. The block adds three things: associative forwarding lookup ports for the RF/FWD stage, a per-stage kill vector for branch flush, and collision detection with a saturating counter.

---
 rtl/odd_wb_pipe.sv | 146 ++++++++++++++
 tb/tb_odd_wb_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_wb_pipe.sv
// Result-staging shift chain for the odd pipeline: fixed-latency units insert at their
// latency stage, entries drain to one registered write-back port, with forwarding lookup.
module odd_wb_pipe #(
    parameter int                     WIDTH     = 128,
    parameter int                     ADDR_W    = 7,
    parameter int                     DEPTH     = 6,
    parameter int                     NUM_UNITS = 3,
    parameter logic [4*NUM_UNITS-1:0] UNIT_LAT  = 12'h164,
    parameter int                     NUM_FWD   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_UNITS-1:0]        unit_valid,
    input  logic [NUM_UNITS*WIDTH-1:0]  unit_data,
    input  logic [NUM_UNITS*ADDR_W-1:0] unit_addr,
    input  logic [DEPTH-1:0]            kill,
    input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr,
    output logic [NUM_FWD-1:0]          fwd_hit,
    output logic [NUM_FWD*WIDTH-1:0]    fwd_data,
    output logic [WIDTH-1:0]            rt_wb,
    output logic [ADDR_W-1:0]           rt_addr_wb,
    output logic                        reg_write_wb,
    output logic                        collision,
    output logic [7:0]                  collision_count
);

    if (DEPTH < 1 || DEPTH > 15) begin : g_bad_depth
        $error("odd_wb_pipe: DEPTH must be in 1..15");
    end
    if (NUM_UNITS < 1 || NUM_UNITS > 8) begin : g_bad_units
        $error("odd_wb_pipe: NUM_UNITS must be in 1..8");
    end
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_lat_chk
        if (UNIT_LAT[4*u+:4] == 4'd0 || int'(UNIT_LAT[4*u+:4]) > DEPTH) begin : g_range
            $error("odd_wb_pipe: unit latency out of range 1..DEPTH");
        end
        for (genvar v = u + 1; v < NUM_UNITS; v++) begin : g_pair
            if (UNIT_LAT[4*u+:4] == UNIT_LAT[4*v+:4]) begin : g_dup
                $error("odd_wb_pipe: unit latencies must be distinct");
            end
        end
    end

    logic [DEPTH:1]    st_v;
    logic [DEPTH:1]    live;
    logic [DEPTH:1]    coll;
    logic [ADDR_W-1:0] st_a [1:DEPTH];
    logic [WIDTH-1:0]  st_d [1:DEPTH];

    // An entry is live only if it is valid and not being killed this cycle.
    assign live = st_v & ~kill;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        logic              ins;
        logic [ADDR_W-1:0] ins_a;
        logic [WIDTH-1:0]  ins_d;
        logic              src_v;
        logic [ADDR_W-1:0] src_a;
        logic [WIDTH-1:0]  src_d;
        logic              v;
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;

        always_comb begin
            ins   = 1'b0;
            ins_a = '0;
            ins_d = '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (unit_valid[u] && UNIT_LAT[4*u+:4] == 4'(k)) begin
                    ins   = 1'b1;
                    ins_a = unit_addr[u*ADDR_W+:ADDR_W];
                    ins_d = unit_data[u*WIDTH+:WIDTH];
                end
            end
        end

        // Stage 1 is fed by the constant empty stage 0.
        if (k == 1) begin : g_head
            assign src_v = 1'b0;
            assign src_a = '0;
            assign src_d = '0;
        end else begin : g_body
            assign src_v = live[k-1];
            assign src_a = st_a[k-1];
            assign src_d = st_d[k-1];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v <= 1'b0;
                a <= '0;
                d <= '0;
            end else if (ins) begin
                v <= 1'b1;
                a <= ins_a;
                d <= ins_d;
            end else begin
                v <= src_v;
                a <= src_a;
                d <= src_d;
            end
        end

        assign st_v[k] = v;
        assign st_a[k] = a;
        assign st_d[k] = d;
        assign coll[k] = ins & src_v;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_wb    <= 1'b0;
            rt_addr_wb      <= '0;
            rt_wb           <= '0;
            collision       <= 1'b0;
            collision_count <= 8'd0;
        end else begin
            reg_write_wb <= live[DEPTH];
            rt_addr_wb   <= st_a[DEPTH];
            rt_wb        <= st_d[DEPTH];
            collision    <= |coll;
            if (|coll && collision_count != 8'hFF) begin
                collision_count <= collision_count + 8'd1;
            end
        end
    end

    // Scan oldest to youngest so the lowest stage index overrides; write-back is the fallback.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int p = 0; p < NUM_FWD; p++) begin
            if (reg_write_wb && rt_addr_wb == fwd_addr[p*ADDR_W+:ADDR_W]) begin
                fwd_hit[p]                = 1'b1;
                fwd_data[p*WIDTH+:WIDTH]  = rt_wb;
            end
            for (int k = DEPTH; k >= 1; k--) begin
                if (live[k] && st_a[k] == fwd_addr[p*ADDR_W+:ADDR_W]) begin
                    fwd_hit[p]               = 1'b1;
                    fwd_data[p*WIDTH+:WIDTH] = st_d[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_odd_wb_pipe.sv
// Self-checking bench for odd_wb_pipe: directed scenarios plus random traffic checked
// against an entry-list reference model of the staging pipe.
module tb_odd_wb_pipe;
    localparam int WIDTH     = 128;
    localparam int ADDR_W    = 7;
    localparam int DEPTH     = 6;
    localparam int NUM_UNITS = 3;
    localparam int NUM_FWD   = 2;
    localparam int LAT [NUM_UNITS] = '{4, 6, 1};

    logic                        clk;
    logic                        reset;
    logic [NUM_UNITS-1:0]        unit_valid;
    logic [NUM_UNITS*WIDTH-1:0]  unit_data;
    logic [NUM_UNITS*ADDR_W-1:0] unit_addr;
    logic [DEPTH-1:0]            kill;
    logic [NUM_FWD*ADDR_W-1:0]   fwd_addr;
    logic [NUM_FWD-1:0]          fwd_hit;
    logic [NUM_FWD*WIDTH-1:0]    fwd_data;
    logic [WIDTH-1:0]            rt_wb;
    logic [ADDR_W-1:0]           rt_addr_wb;
    logic                        reg_write_wb;
    logic                        collision;
    logic [7:0]                  collision_count;

    odd_wb_pipe dut (
        .clk(clk), .reset(reset), .unit_valid(unit_valid), .unit_data(unit_data),
        .unit_addr(unit_addr), .kill(kill), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb),
        .reg_write_wb(reg_write_wb), .collision(collision), .collision_count(collision_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
        int                pos;
    } ent_t;

    ent_t              q[$];
    logic              m_wb_v;
    logic [ADDR_W-1:0] m_wb_a;
    logic [WIDTH-1:0]  m_wb_d;
    logic              m_coll;
    int                m_cnt;
    logic              m_zero;
    int                n_checks = 0;
    int                n_err    = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fwd();
        for (int p = 0; p < NUM_FWD; p++) begin
            logic              hit;
            logic [WIDTH-1:0]  d;
            logic [ADDR_W-1:0] a;
            int                best;
            hit  = 1'b0;
            d    = '0;
            best = DEPTH + 1;
            a    = fwd_addr[p*ADDR_W+:ADDR_W];
            foreach (q[i]) begin
                if (!kill[q[i].pos-1] && q[i].a == a && q[i].pos < best) begin
                    best = q[i].pos;
                    hit  = 1'b1;
                    d    = q[i].d;
                end
            end
            if (!hit && m_wb_v && m_wb_a == a) begin
                hit = 1'b1;
                d   = m_wb_d;
            end
            chk($sformatf("fwd_hit%0d", p), WIDTH'(fwd_hit[p]), WIDTH'(hit));
            chk($sformatf("fwd_data%0d", p), fwd_data[p*WIDTH+:WIDTH], d);
        end
    endtask

    task automatic check_outputs();
        chk("reg_write_wb", WIDTH'(reg_write_wb), WIDTH'(m_wb_v));
        if (m_wb_v || m_zero) begin
            chk("rt_addr_wb", WIDTH'(rt_addr_wb), WIDTH'(m_wb_a));
            chk("rt_wb", rt_wb, m_wb_d);
        end
        chk("collision", WIDTH'(collision), WIDTH'(m_coll));
        chk("collision_count", WIDTH'(collision_count), WIDTH'(m_cnt));
        check_fwd();
    endtask

    task automatic model_step();
        ent_t nq[$];
        logic coll;
        if (reset) begin
            q.delete();
            m_wb_v = 1'b0;
            m_wb_a = '0;
            m_wb_d = '0;
            m_coll = 1'b0;
            m_cnt  = 0;
            m_zero = 1'b1;
            return;
        end
        m_zero = 1'b0;
        m_wb_v = 1'b0;
        foreach (q[i]) begin
            ent_t e;
            e = q[i];
            if (kill[e.pos-1]) continue;
            if (e.pos == DEPTH) begin
                m_wb_v = 1'b1;
                m_wb_a = e.a;
                m_wb_d = e.d;
            end else begin
                e.pos++;
                nq.push_back(e);
            end
        end
        coll = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_valid[u]) begin
                ent_t e;
                for (int i = nq.size() - 1; i >= 0; i--) begin
                    if (nq[i].pos == LAT[u]) begin
                        nq.delete(i);
                        coll = 1'b1;
                    end
                end
                e.a   = unit_addr[u*ADDR_W+:ADDR_W];
                e.d   = unit_data[u*WIDTH+:WIDTH];
                e.pos = LAT[u];
                nq.push_back(e);
            end
        end
        q      = nq;
        m_coll = coll;
        if (coll && m_cnt < 255) m_cnt++;
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
        unit_valid = '0;
        kill       = '0;
    endtask

    task automatic put(input int u, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        unit_valid[u]                = 1'b1;
        unit_addr[u*ADDR_W+:ADDR_W]  = a;
        unit_data[u*WIDTH+:WIDTH]    = d;
    endtask

    function automatic logic [WIDTH-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset      = 1'b1;
        unit_valid = '0;
        unit_data  = '0;
        unit_addr  = '0;
        kill       = '0;
        fwd_addr   = '0;
        @(posedge clk);
        @(negedge clk);
        model_step();
        reset = 1'b0;
        cycle();

        // Branch, LS and perm paths
        put(2, 7'd5, 128'hA5);
        cycle();
        repeat (9) cycle();
        put(1, 7'd9, 128'h1234);
        put(0, 7'd10, 128'h5678);
        cycle();
        repeat (7) cycle();

        // Collision: branch entry overrun by a perm insertion
        put(2, 7'd1, 128'h11);
        cycle();
        repeat (2) cycle();
        put(0, 7'd2, 128'h22);
        cycle();
        repeat (7) cycle();

        // Forwarding: addr 9 youngest in stage 2 (X), older in stage 5 (Y)
        put(0, 7'd9, 128'hBBBB);
        put(2, 7'd9, 128'hAAAA);
        cycle();
        fwd_addr = {7'd3, 7'd9};
        cycle();
        check_fwd();
        kill = 6'b000010;
        cycle();
        fwd_addr = {7'd9, 7'd10};
        repeat (8) cycle();

        // Kill at the last stage and at stage 1
        put(2, 7'd4, 128'h44);
        cycle();
        repeat (5) cycle();
        kill = 6'b100000;
        cycle();
        cycle();
        put(2, 7'd6, 128'h66);
        cycle();
        kill = 6'b000001;
        cycle();
        repeat (8) cycle();

        // Reset with entries in flight and all units presenting
        put(0, 7'd1, rnd_data());
        put(1, 7'd2, rnd_data());
        put(2, 7'd3, rnd_data());
        cycle();
        put(2, 7'd4, rnd_data());
        cycle();
        reset = 1'b1;
        put(0, 7'd1, rnd_data());
        put(1, 7'd2, rnd_data());
        put(2, 7'd3, rnd_data());
        cycle();
        reset = 1'b0;
        repeat (9) cycle();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if ($urandom_range(0, 2) == 0) put(u, 7'($urandom_range(0, 7)), rnd_data());
            end
            kill     = 6'($urandom & $urandom & $urandom);
            fwd_addr = {7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
            cycle();
        end

        // Continuous collisions drive the counter into saturation
        for (int n = 0; n < 300; n++) begin
            for (int u = 0; u < NUM_UNITS; u++) put(u, 7'($urandom_range(0, 7)), rnd_data());
            cycle();
        end
        repeat (3) cycle();
        chk("count_saturated", WIDTH'(collision_count), WIDTH'(255));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
